// File: rtl/enc_dec_pkg.sv
// Shared constants, types and helpers for the encoder/decoder family.
//   CODE_W / ONEHOT_W : binary index width and matching one-hot width
//   dec_state_e       : decoder pulse FSM states
//   dec_out_t         : registered decoder output payload
//   onehot_of()       : binary code to one-hot vector
package enc_dec_pkg;

  localparam int unsigned CODE_W   = 3;
  localparam int unsigned ONEHOT_W = 8;

  typedef logic [CODE_W-1:0]   code_t;
  typedef logic [ONEHOT_W-1:0] onehot_t;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } dec_state_e;

  typedef struct packed {
    onehot_t vec;
    code_t   code;
    logic    valid;
  } dec_out_t;

  // Expand a binary index to its one-hot vector.
  function automatic onehot_t onehot_of(input code_t code);
    return onehot_t'(1) << code;
  endfunction

endpackage

// File: rtl/dec_3_8_pulse_if.sv
// Handshake and output bundle of the 3-to-8 pulse decoder.
//   en, in_valid, in_code : code source side (driven by master)
//   in_ready              : decoder can take a code this cycle
//   out, out_code         : one-hot vector and its binary code
//   out_valid, busy       : pulse active / pulse active or code pending
interface dec_3_8_pulse_if;
  import enc_dec_pkg::*;

  logic    en;
  logic    in_valid;
  code_t   in_code;
  logic    in_ready;
  onehot_t out;
  code_t   out_code;
  logic    out_valid;
  logic    busy;

  modport master (
    output en, in_valid, in_code,
    input  in_ready, out, out_code, out_valid, busy
  );

  modport slave (
    input  en, in_valid, in_code,
    output in_ready, out, out_code, out_valid, busy
  );

endinterface

// File: rtl/dec_pend_buf.sv
// Single-entry code buffer holding the next code while a pulse runs.
//   clk, rst : clock, synchronous active-high reset
//   wr       : store wr_code and mark full
//   rd       : release the entry (mark empty)
//   full     : entry holds a code
//   rd_code  : stored code
module dec_pend_buf
  import enc_dec_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr,
  input  logic  rd,
  input  code_t wr_code,
  output logic  full,
  output code_t rd_code
);

  // Write wins over read; the parent never issues both in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 1'b0;
      rd_code <= '0;
    end else if (wr) begin
      full    <= 1'b1;
      rd_code <= wr_code;
    end else if (rd) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/dec_3_8_pulse.sv
// Registered 3-to-8 one-hot decoder holding each code for PULSE_LEN cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of dec_3_8_pulse_if
//              (en/in_valid/in_code/in_ready handshake in,
//               out/out_code/out_valid/busy status out)
// A one-entry pending buffer lets the next code start right after the
// current pulse with no idle cycle.
module dec_3_8_pulse
  import enc_dec_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  dec_3_8_pulse_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PULSE_LEN - 1);

  dec_state_e       state;
  logic [CNT_W-1:0] cnt;
  dec_out_t         out_q;

  logic  pend_full;
  code_t pend_code;
  logic  ready;
  logic  accept;
  logic  last;
  logic  pend_wr;
  logic  pend_rd;

  // Ready is forced low during reset so a reset-cycle handshake is dropped.
  assign ready   = bus.en & ~pend_full & ~rst;
  assign accept  = bus.in_valid & ready;
  assign last    = (state == PULSE) && (cnt == '0);
  // Mid-pulse accepts park in the buffer; last-cycle accepts bypass it.
  assign pend_wr = accept && (state == PULSE) && !last;
  assign pend_rd = last && pend_full;

  dec_pend_buf u_pend (
    .clk     (clk),
    .rst     (rst),
    .wr      (pend_wr),
    .rd      (pend_rd),
    .wr_code (bus.in_code),
    .full    (pend_full),
    .rd_code (pend_code)
  );

  // Pulse FSM, down-counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_q.vec   <= onehot_of(bus.in_code);
            out_q.code  <= bus.in_code;
            out_q.valid <= 1'b1;
            cnt         <= CNT_RELOAD;
            state       <= PULSE;
          end
        end
        PULSE: begin
          if (!last) begin
            cnt <= cnt - CNT_W'(1);
          end else if (pend_full) begin
            out_q.vec   <= onehot_of(pend_code);
            out_q.code  <= pend_code;
            out_q.valid <= 1'b1;
            cnt         <= CNT_RELOAD;
          end else if (accept) begin
            out_q.vec   <= onehot_of(bus.in_code);
            out_q.code  <= bus.in_code;
            out_q.valid <= 1'b1;
            cnt         <= CNT_RELOAD;
          end else begin
            out_q.vec   <= '0;
            out_q.valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          out_q <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out       = out_q.vec;
  assign bus.out_code  = out_q.code;
  assign bus.out_valid = out_q.valid;
  assign bus.busy      = out_q.valid | pend_full;

endmodule

// File: doc/dec_3_8_pulse.md
Name: dec_3_8_pulse

Overview:
Registered 3-to-8 one-hot decoder with a pulse timer. It is the receive-side counterpart of the 8-to-3 priority encoder in the combinational encoder set.
- Accepts a 3-bit code over a valid/ready handshake.
- Drives the matching one-hot line for PULSE_LEN clock cycles.
- Holds one further code in a single-entry pending buffer, so pulses can run back-to-back with no gap.
- Used downstream of an encoder to re-expand an index into a select/strobe vector.

Parameters:
PULSE_LEN, 4, cycles each one-hot pulse is held; legal range 1..255.
CNT_W, 8, width of the pulse down-counter; must satisfy 2**CNT_W > PULSE_LEN-1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  enable; when 0 no new codes are accepted
in_valid  input  1  in_code is valid this cycle
in_code  input  3  binary index to decode
in_ready  output  1  block can accept a code this cycle
out  output  8  one-hot decoded vector, registered; all-zero when idle
out_code  output  3  binary code currently driven on out (for checking)
out_valid  output  1  a pulse is active (out != 0)
busy  output  1  a pulse is active or the pending buffer is full

Behaviour:
- Clock, reset and enable:
  - One clock; reset is synchronous and active-high. The clock and reset ports are named clk and rst.
  - Reset values: out=8'h00, out_code=3'd0, out_valid=0, state=IDLE, cnt=0, pending empty.
  - in_ready = en & ~pend_full (combinational). It reads 0 in the cycle rst is high. Any handshake in a reset cycle is discarded.
  - Accept condition: in_valid & in_ready at a rising edge.
- FSM states: IDLE and PULSE.
- IDLE:
  - On accept: next cycle out = 8'b1 << in_code, out_code = in_code, out_valid=1, cnt = PULSE_LEN-1, go to PULSE.
  - Latency from accept edge to out asserted is 1 cycle.
- PULSE with cnt != 0:
  - cnt decrements by 1; out is held.
  - An accept while pending is empty writes the code into pending.
- PULSE with cnt == 0 (last cycle of the pulse). Next state is decided by:
  - Pending full: load pending into out/out_code, cnt = PULSE_LEN-1, clear pending, stay in PULSE. No idle cycle is inserted.
  - Pending empty and accept this cycle: the accepted code bypasses pending and loads straight into out, cnt = PULSE_LEN-1, stay in PULSE.
  - Pending empty and no accept: out=0, out_valid=0, go to IDLE.
- Pending buffer:
  - One entry.
  - When full, in_ready=0, so a code is never overwritten or dropped.
- Pulse length:
  - Each accepted code produces exactly PULSE_LEN consecutive cycles of its one-hot output.
  - Codes are emitted in acceptance order.
- PULSE_LEN=1: every pulse lasts 1 cycle, and a continuous input stream gives one code per cycle at full throughput.
- en deasserted mid-pulse: the current pulse and any pending code drain normally; only new accepts are blocked.
- Reset mid-pulse: out clears on the next edge and the pending code is lost.
- out is always either zero or exactly one-hot; it never has two bits set.
- busy = out_valid | pend_full.

Decomposition:
- Shared package (enc_dec_pkg):
  - CODE_W=3 and ONEHOT_W=8 constants.
  - FSM state typedef {IDLE, PULSE}.
  - A function onehot_of(code) returning 1<<code.
  - The encoder family reuses these constants.
- Sub-module: dec_pend_buf, the single-entry code buffer (full flag plus 3-bit data register with write/read strobes). The top level holds the FSM, the counter and the output registers.

Test Plan (all with PULSE_LEN=4 except where noted):
- Reset then idle: rst high 2 cycles with in_valid=1 -> out=8'h00, out_valid=0 and in_ready=0 during reset; no pulse appears after reset deasserts unless a new accept occurs.
- Single code: accept in_code=3'd5 at cycle 0 -> out=8'h20 and out_code=5 in cycles 1-4; out=8'h00 and out_valid=0 at cycle 5.
- Back-to-back: accept 3'd0 at cycle 0 and 3'd7 at cycle 2 -> out=8'h01 in cycles 1-4, out=8'h80 in cycles 5-8, no zero cycle between; in_ready=0 from cycle 3 until cycle 5.
- Backpressure: hold in_valid=1 with codes 1, 2, 3 -> code 3 is not accepted until pending frees at cycle 5; outputs are 8'h02, 8'h04, 8'h08, each exactly 4 cycles, in order.
- en gating and bypass: en=0 with in_valid=1 and code 4 -> no accept, out stays 0. Then en=1 and an accept on the last cycle of a running pulse with pending empty -> the new one-hot follows immediately.
- PULSE_LEN=1 streaming: codes 0..7 on consecutive cycles -> out = 01, 02, 04, ..., 80 on consecutive cycles, in_ready constantly 1. Also assert rst mid-stream -> out=0 on the following cycle.
